ifu_fetch: RTL and testbench

- Instruction fetch unit. Produces the 32-bit instruction word and PC consumed by the instruction decoder.
- Owns the PC and issues in-order word reads to the instruction memory port.
- Buffers returned words in a small FIFO and hands them to decode over a valid/ready handshake.
- Redirects from branch/jump resolution flush in-flight and buffered fetches.

---
 rtl/ifu_fetch_if.sv | 76 +++++++
 rtl/ifu_fetch.sv | 190 +++++++++++++++++++
 tb/tb_ifu_fetch.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bundle: redirect input, imem request/response and decode handoff.
// The fault signal exists only when IFU_MISALIGN_TRAP_EN is defined.
interface ifu_fetch_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
`ifdef IFU_MISALIGN_TRAP_EN
   logic        fault;

   modport master (
      input  redirect_valid,
      input  redirect_pc,
      output imem_req_valid,
      input  imem_req_ready,
      output imem_req_addr,
      input  imem_resp_valid,
      input  imem_resp_data,
      output inst_valid,
      input  inst_ready,
      output inst,
      output inst_pc,
      output fault
   );

   modport slave (
      output redirect_valid,
      output redirect_pc,
      input  imem_req_valid,
      output imem_req_ready,
      input  imem_req_addr,
      output imem_resp_valid,
      output imem_resp_data,
      input  inst_valid,
      output inst_ready,
      input  inst,
      input  inst_pc,
      input  fault
   );
`else
   modport master (
      input  redirect_valid,
      input  redirect_pc,
      output imem_req_valid,
      input  imem_req_ready,
      output imem_req_addr,
      input  imem_resp_valid,
      input  imem_resp_data,
      output inst_valid,
      input  inst_ready,
      output inst,
      output inst_pc
   );

   modport slave (
      output redirect_valid,
      output redirect_pc,
      input  imem_req_valid,
      output imem_req_ready,
      input  imem_req_addr,
      output imem_resp_valid,
      output imem_resp_data,
      input  inst_valid,
      output inst_ready,
      input  inst,
      input  inst_pc
   );
`endif
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC owner, credit-limited imem reads, tag FIFO, inst FIFO.
// Define IFU_MISALIGN_TRAP_EN to trap misaligned redirects via bus.fault.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input logic         clock,
   input logic         reset_n,
   ifu_fetch_if.master bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic             epoch_q, epoch_d;
   logic [CNT_W-1:0] osd_q, osd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] twr_q, twr_d;
   logic [PTR_W-1:0] trd_q, trd_d;
   logic [PTR_W-1:0] fwr_q, fwr_d;
   logic [PTR_W-1:0] frd_q, frd_d;

   logic [31:0] tag_pc_q   [0:DEPTH-1];
   logic        tag_ep_q   [0:DEPTH-1];
   logic [31:0] fifo_data_q[0:DEPTH-1];
   logic [31:0] fifo_pc_q  [0:DEPTH-1];

   logic redir;
   logic halt;
   logic credit_ok;
   logic req_valid;
   logic req_fire;
   logic resp_fire;
   logic push;
   logic inst_valid;
   logic pop;

`ifdef IFU_MISALIGN_TRAP_EN
   logic fault_q, fault_d;
   logic misalign;

   assign misalign = bus.redirect_pc[1:0] != 2'b00;
   assign halt     = fault_q;
   assign bus.fault = fault_q;
`else
   logic unused_lo;

   // Low PC bits are forced to zero, so they never reach any logic.
   assign unused_lo = ^bus.redirect_pc[1:0];
   assign halt      = 1'b0;
`endif

   assign redir = bus.redirect_valid;

   always_comb begin
      credit_ok  = (osd_q + cnt_q) < CNT_MAX;
      req_valid  = (state_q == FETCH) && credit_ok && !redir && !halt;
      req_fire   = req_valid && bus.imem_req_ready;
      resp_fire  = bus.imem_resp_valid && (osd_q != '0);
      // Stale epoch or a coincident redirect both discard the word.
      push       = resp_fire && (tag_ep_q[trd_q] == epoch_q) && !redir;
      inst_valid = (cnt_q != '0) && !halt;
      pop        = inst_valid && bus.inst_ready;
   end

   always_comb begin
      pc_d    = pc_q;
      epoch_d = epoch_q;
      osd_d   = osd_q;
      twr_d   = twr_q;
      trd_d   = trd_q;
      fwr_d   = fwr_q;
      frd_d   = frd_q;
      cnt_d   = cnt_q;

      if (req_fire) begin
         osd_d = osd_d + CNT_ONE;
         twr_d = twr_q + PTR_ONE;
      end
      if (resp_fire) begin
         osd_d = osd_d - CNT_ONE;
         trd_d = trd_q + PTR_ONE;
      end

      if (redir) begin
         pc_d    = {bus.redirect_pc[31:2], 2'b00};
         epoch_d = ~epoch_q;
         fwr_d   = '0;
         frd_d   = '0;
         cnt_d   = '0;
      end else begin
         if (req_fire) begin
            pc_d = pc_q + 32'd4;
         end
         if (push) begin
            fwr_d = fwr_q + PTR_ONE;
            cnt_d = cnt_d + CNT_ONE;
         end
         if (pop) begin
            frd_d = frd_q + PTR_ONE;
            cnt_d = cnt_d - CNT_ONE;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (redir) begin
         state_d = (osd_d != '0) ? FLUSH : FETCH;
      end else begin
         unique case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            FLUSH:   state_d = (osd_d == '0) ? FETCH : FLUSH;
            default: state_d = BOOT;
         endcase
      end
   end

`ifdef IFU_MISALIGN_TRAP_EN
   always_comb begin
      fault_d = fault_q;
      if (redir) begin
         fault_d = misalign;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         epoch_q <= 1'b0;
         osd_q   <= '0;
         cnt_q   <= '0;
         twr_q   <= '0;
         trd_q   <= '0;
         fwr_q   <= '0;
         frd_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epoch_q <= epoch_d;
         osd_q   <= osd_d;
         cnt_q   <= cnt_d;
         twr_q   <= twr_d;
         trd_q   <= trd_d;
         fwr_q   <= fwr_d;
         frd_q   <= frd_d;
      end
   end

   // Storage needs no reset: occupancy counters gate every read.
   always_ff @(posedge clock) begin
      if (req_fire) begin
         tag_pc_q[twr_q] <= pc_q;
         tag_ep_q[twr_q] <= epoch_q;
      end
      if (push) begin
         fifo_data_q[fwr_q] <= bus.imem_resp_data;
         fifo_pc_q[fwr_q]   <= tag_pc_q[trd_q];
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc_q;
   assign bus.inst_valid     = inst_valid;
   assign bus.inst    = inst_valid ? fifo_data_q[frd_q] : '0;
   assign bus.inst_pc = inst_valid ? fifo_pc_q[frd_q] : '0;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch with an in-order, variable-latency imem model.
// Fault checks are compiled in when IFU_MISALIGN_TRAP_EN is defined.
module tb_ifu_fetch;

   localparam int DEPTH = 2;

   logic clock = 1'b0;
   logic reset_n = 1'b0;

   always #5 clock = ~clock;

   ifu_fetch_if bus ();

   ifu_fetch #(
      .RESET_PC(32'h8000_0000),
      .DEPTH   (DEPTH)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } pend_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   pend_t       pend[$];
   exp_t        sb[$];
   logic [31:0] req_log[$];

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          lat = 1;
   int          n_cons = 0;
   int          n_fire = 0;
   bit          rdy_rand = 0;
   logic        ird = 1'b1;
   logic [31:0] exp_addr = 32'h8000_0000;
   bit          fault_exp = 0;
   bit          last_redir = 0;
   bit          want_first = 0;
   logic [31:0] first_pc = 32'hDEAD_BEEF;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   // mode 0: no redirect, 1: redirect now, 2: redirect only if a
   // response and an inst handshake coincide this cycle
   task automatic step(input int mode, input logic [31:0] tgt);
      bit   pres;
      bit   redir;
      int   stale_n;
      logic [31:0] a;
      @(negedge clock);
      cyc++;
      pres = (pend.size() > 0) && (pend[0].due <= cyc);
      bus.imem_resp_valid = pres;
      bus.imem_resp_data  = pres ? mem_word(pend[0].addr) : 32'h0;
      bus.imem_req_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.inst_ready      = ird;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = tgt;
      #1;
      redir = (mode == 1) ||
              (mode == 2 && pres && bus.inst_valid && bus.inst_ready);
      bus.redirect_valid = redir;
      #1;
      last_redir = redir;

      stale_n = 0;
      foreach (pend[i]) if (pend[i].stale) stale_n++;
      if (stale_n > 0 || fault_exp) chk("noreq_flush", bus.imem_req_valid, 0);
      if (redir) chk("noreq_redir", bus.imem_req_valid, 0);
      if (sb.size() >= DEPTH) chk("credit", bus.imem_req_valid, 0);
      if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_addr);
`ifdef IFU_MISALIGN_TRAP_EN
      chk("fault", bus.fault, fault_exp);
      if (fault_exp) chk("fault_inst", bus.inst_valid, 0);
`endif

      if (bus.inst_valid) begin
         if (sb.size() == 0) begin
            chk("stray_inst", bus.inst_valid, 0);
         end else begin
            chk("inst_pc", bus.inst_pc, sb[0].pc);
            chk("inst", bus.inst, sb[0].data);
            if (bus.inst_ready) begin
               if (want_first) begin
                  first_pc   = bus.inst_pc;
                  want_first = 0;
               end
               void'(sb.pop_front());
               n_cons++;
            end
         end
      end

      if (pres) void'(pend.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         a = bus.imem_req_addr;
         pend.push_back('{addr: a, due: cyc + lat, stale: 1'b0});
         sb.push_back('{pc: exp_addr, data: mem_word(exp_addr)});
         req_log.push_back(a);
         exp_addr = exp_addr + 32'd4;
         n_fire++;
      end
      if (redir) begin
         sb.delete();
         req_log.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
         exp_addr   = {tgt[31:2], 2'b00};
         want_first = 1;
         first_pc   = 32'hDEAD_BEEF;
`ifdef IFU_MISALIGN_TRAP_EN
         fault_exp = (tgt[1:0] != 2'b00);
`endif
      end
   endtask

   initial begin
      int base;
      bit hit;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = 32'h0;
      bus.imem_req_ready  = 1'b1;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      bus.inst_ready      = 1'b1;

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_req_valid", bus.imem_req_valid, 0);
      chk("rst_inst_valid", bus.inst_valid, 0);
      chk("rst_req_addr", bus.imem_req_addr, 32'h8000_0000);
      chk("rst_inst", bus.inst, 0);
      chk("rst_inst_pc", bus.inst_pc, 0);
`ifdef IFU_MISALIGN_TRAP_EN
      chk("rst_fault", bus.fault, 0);
`endif
      reset_n = 1'b1;
      #2;
      chk("boot_idle", bus.imem_req_valid, 0);

      step(0, 32'h0);
      chk("first_req", bus.imem_req_valid, 1);
      chk("first_addr", bus.imem_req_addr, 32'h8000_0000);
      repeat (12) step(0, 32'h0);
      chk("stream_progress", 32'(n_cons >= 3), 1);

      ird  = 1'b0;
      base = n_fire;
      repeat (10) step(0, 32'h0);
      chk("stall_reqs", 32'(n_fire - base <= DEPTH), 1);
      chk("stall_req_off", bus.imem_req_valid, 0);
      chk("stall_hold", bus.inst_valid, 1);
      ird  = 1'b1;
      base = n_cons;
      repeat (10) step(0, 32'h0);
      chk("resume_progress", 32'(n_cons - base >= 3), 1);

      lat = 3;
      for (int i = 0; i < 50 && pend.size() != 2; i++) step(0, 32'h0);
      chk("two_outstanding", pend.size(), 2);
      step(1, 32'h8000_0100);
      repeat (20) step(0, 32'h0);
      chk("redir_first_pc", first_pc, 32'h8000_0100);

      lat = 1;
      repeat (5) step(0, 32'h0);
      hit = 0;
      for (int i = 0; i < 50 && !hit; i++) begin
         step(2, 32'h8000_0200);
         hit = last_redir;
      end
      chk("coincide_found", hit, 1);
      repeat (10) step(0, 32'h0);
      chk("coincide_first_pc", first_pc, 32'h8000_0200);

      step(1, 32'hFFFF_FFFC);
      repeat (10) step(0, 32'h0);
      if (req_log.size() >= 2) begin
         chk("wrap_req0", req_log[0], 32'hFFFF_FFFC);
         chk("wrap_req1", req_log[1], 32'h0000_0000);
      end else begin
         chk("wrap_req_cnt", req_log.size(), 2);
      end
      chk("wrap_first_pc", first_pc, 32'hFFFF_FFFC);

      rdy_rand = 1;
      base = n_cons;
      for (int i = 0; i < 80; i++) begin
         lat = $urandom_range(1, 3);
         ird = 1'($urandom_range(0, 1));
         step((i == 40) ? 1 : 0, 32'h8000_1000);
      end
      rdy_rand = 0;
      ird = 1'b1;
      lat = 1;
      repeat (10) step(0, 32'h0);
      chk("random_progress", 32'(n_cons - base >= 10), 1);

`ifdef IFU_MISALIGN_TRAP_EN
      step(1, 32'h8000_0102);
      repeat (6) step(0, 32'h0);
      chk("fault_set", bus.fault, 1);
      chk("fault_noreq", bus.imem_req_valid, 0);
      step(1, 32'h8000_0104);
      repeat (8) step(0, 32'h0);
      chk("fault_clr", bus.fault, 0);
      chk("fault_first_pc", first_pc, 32'h8000_0104);
`else
      step(1, 32'h8000_0102);
      repeat (8) step(0, 32'h0);
      chk("align_first_pc", first_pc, 32'h8000_0100);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
